// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the FIR run controller.
// Holds the FSM state encoding and debounce counter sizing.
package fir_ctrl_pkg;

   typedef enum logic [2:0] {
      OFF,
      RESET,
      RUN,
      STEP_WAIT,
      STEP,
      HALT
   } ctrl_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int RST_CYCLES_DEF      = 4;

   function automatic int db_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int DB_CNT_W_DEF = db_cnt_w(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle pulse on each accepted press.
module button_debouncer
   import fir_ctrl_pkg::*;
#(
   parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int              CW  = db_cnt_w(CYCLES);
   localparam logic [CW-1:0]   SAT = CW'(CYCLES);

   logic          s1_q, s2_q, prev_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_d is the run length of the synced level, including this cycle
   always_comb begin
      cnt_d = CW'(1);
      if (s2_q == prev_q) begin
         cnt_d = (cnt_q == SAT) ? SAT : cnt_q + CW'(1);
      end
      level_d = (cnt_d == SAT) ? s2_q : level_q;
      press_d = level_q & ~level_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         s1_q    <= raw;
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/fir_run_controller.sv
// Run/step/halt control for the FIR processor: debounced buttons,
// core clock-enable and reset generation, program-end freeze.
module fir_run_controller
   import fir_ctrl_pkg::*;
#(
   parameter int             N               = 24,
   parameter int             DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int             RST_CYCLES      = RST_CYCLES_DEF,
   parameter logic [N-1:0]   HALT_PC         = N'('hFFC),
   parameter int             CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwr,
   input  logic             dbg,
   input  logic             stp,
   input  logic [N-1:0]     pc,
   output logic             core_en,
   output logic             core_rst,
   output logic             dbg_mode,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);

   localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

   logic [2:0] btn_raw, btn_lvl, btn_press;
   logic       pwr_press, dbg_press, stp_press, dbg_level, pc_hit;
   logic       unused_lvl;

   assign btn_raw = {stp, dbg, pwr};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      button_debouncer #(
         .CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_lvl[i]),
         .press (btn_press[i])
      );
   end

   assign pwr_press  = btn_press[0];
   assign dbg_press  = btn_press[1];
   assign stp_press  = btn_press[2];
   assign dbg_level  = btn_lvl[1];
   assign unused_lvl = btn_lvl[0] ^ btn_lvl[2];
   assign pc_hit     = (pc == HALT_PC);

   ctrl_state_t      state_q, state_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] step_count_q, step_count_d;
   logic             core_en_q, core_en_d;
   logic             core_rst_q, core_rst_d;
   logic             dbg_mode_q, dbg_mode_d;
   logic             halted_q, halted_d;

   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      step_count_d = step_count_q;
      if (pwr_press) begin
         state_d      = RESET;
         rst_cnt_d    = '0;
         step_count_d = '0;
      end else begin
         unique case (state_q)
            RESET: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_d = dbg_level ? RUN : STEP_WAIT;
               end else begin
                  rst_cnt_d = rst_cnt_q + RW'(1);
               end
            end
            RUN: begin
               if (pc_hit)         state_d = HALT;
               else if (dbg_press) state_d = STEP_WAIT;
            end
            // a coincident stp press loses to dbg and is dropped
            STEP_WAIT: begin
               if (dbg_press) begin
                  state_d = RUN;
               end else if (stp_press) begin
                  state_d      = STEP;
                  step_count_d = step_count_q + CNT_W'(1);
               end
            end
            STEP:    state_d = pc_hit ? HALT : STEP_WAIT;
            default: state_d = state_q;
         endcase
      end
      core_en_d  = (state_d == RESET) || (state_d == RUN) ||
                   (state_d == STEP);
      core_rst_d = (state_d == OFF) || (state_d == RESET);
      dbg_mode_d = (state_d == STEP_WAIT) || (state_d == STEP);
      halted_d   = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= OFF;
         rst_cnt_q    <= '0;
         step_count_q <= '0;
         core_en_q    <= 1'b0;
         core_rst_q   <= 1'b1;
         dbg_mode_q   <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         step_count_q <= step_count_d;
         core_en_q    <= core_en_d;
         core_rst_q   <= core_rst_d;
         dbg_mode_q   <= dbg_mode_d;
         halted_q     <= halted_d;
      end
   end

   assign core_en    = core_en_q;
   assign core_rst   = core_rst_q;
   assign dbg_mode   = dbg_mode_q;
   assign halted     = halted_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_fir_run_controller.sv
// Bench for fir_run_controller: per-cycle reference model feeding a
// scoreboard queue, directed scenarios followed by random buttons.
module tb_fir_run_controller;

   localparam int          N   = 24;
   localparam int          DB  = 4;
   localparam int          RC  = 4;
   localparam int          CW  = 4;
   localparam logic [23:0] HPC = 24'h40;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    btn = 3'b111;
   logic [N-1:0]  pc  = '0;
   logic          core_en, core_rst, dbg_mode, halted;
   logic [CW-1:0] step_count;

   fir_run_controller #(
      .N               (N),
      .DEBOUNCE_CYCLES (DB),
      .RST_CYCLES      (RC),
      .HALT_PC         (HPC),
      .CNT_W           (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwr        (btn[0]),
      .dbg        (btn[1]),
      .stp        (btn[2]),
      .pc         (pc),
      .core_en    (core_en),
      .core_rst   (core_rst),
      .dbg_mode   (dbg_mode),
      .halted     (halted),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic          rs;
      logic          dm;
      logic          ht;
      logic [CW-1:0] sc;
   } exp_t;

   typedef enum int {M_OFF, M_RESET, M_RUN, M_WAIT, M_STEP, M_HALT} mode_t;

   localparam exp_t RST_EXP = '{en: 1'b0, rs: 1'b1, dm: 1'b0, ht: 1'b0, sc: '0};

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         en_cnt = 0;

   // reference model state
   mode_t      mode;
   int         rst_left;
   int         steps;
   logic [2:0] db;
   logic [2:0] prs;
   logic [2:0] hist[$];

   function automatic exp_t exp_now();
      exp_t e;
      e.en = (mode == M_RESET) || (mode == M_RUN) || (mode == M_STEP);
      e.rs = (mode == M_OFF) || (mode == M_RESET);
      e.dm = (mode == M_WAIT) || (mode == M_STEP);
      e.ht = (mode == M_HALT);
      e.sc = CW'(steps);
      return e;
   endfunction

   task automatic model_reset();
      mode     = M_OFF;
      rst_left = 0;
      steps    = 0;
      db       = 3'b111;
      prs      = 3'b000;
      hist     = {};
      repeat (DB + 2) hist.push_back(3'b111);
   endtask

   task automatic model_step();
      logic [2:0] p, nd;
      logic       dl;
      bit         all1, all0;
      p  = prs;
      dl = db[1];
      if (mode == M_RESET && !p[0]) begin
         rst_left--;
         if (rst_left == 0) mode = dl ? M_RUN : M_WAIT;
      end else if (p[0]) begin
         mode     = M_RESET;
         rst_left = RC;
         steps    = 0;
      end else begin
         case (mode)
            M_RUN: begin
               if (pc == HPC) mode = M_HALT;
               else if (p[1]) mode = M_WAIT;
            end
            M_WAIT: begin
               if (p[1]) begin
                  mode = M_RUN;
               end else if (p[2]) begin
                  mode  = M_STEP;
                  steps = (steps + 1) % (1 << CW);
               end
            end
            M_STEP:  mode = (pc == HPC) ? M_HALT : M_WAIT;
            default: ;
         endcase
      end
      // window = the DB synced samples seen before this edge
      hist.push_back(btn);
      if (hist.size() > DB + 2) void'(hist.pop_front());
      for (int b = 0; b < 3; b++) begin
         all1 = 1'b1;
         all0 = 1'b1;
         for (int i = 0; i < DB; i++) begin
            if (hist[i][b]) all0 = 1'b0;
            else            all1 = 1'b0;
         end
         nd[b] = all1 ? 1'b1 : (all0 ? 1'b0 : db[b]);
      end
      prs = db & ~nd;
      db  = nd;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_reset();
         else      model_step();
         sb.push_back(exp_now());
      end
   end

   exp_t mon_e, mon_a;

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (!rst) mon_e = RST_EXP;
            mon_a = '{en: core_en, rs: core_rst, dm: dbg_mode,
                      ht: halted, sc: step_count};
            checks++;
            if (mon_a !== mon_e) begin
               errors++;
               $display("FAIL cycle@%0t: got en=%b rst=%b dm=%b h=%b sc=%0d required en=%b rst=%b dm=%b h=%b sc=%0d",
                        $time, mon_a.en, mon_a.rs, mon_a.dm, mon_a.ht, mon_a.sc,
                        mon_e.en, mon_e.rs, mon_e.dm, mon_e.ht, mon_e.sc);
            end
         end
         if (rst && core_en) en_cnt++;
      end
   end

   task automatic dchk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   task automatic hit(input int b, input int lo, input int hi);
      @(negedge clk);
      btn[b] = 1'b0;
      repeat (lo) @(negedge clk);
      btn[b] = 1'b1;
      repeat (hi) @(negedge clk);
   endtask

   int  en0;
   bit  found;

   initial begin
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);

      // glitch then clean power press
      btn[0] = 1'b0;
      @(negedge clk);
      btn[0] = 1'b1;
      repeat (10) @(negedge clk);
      dchk("glitch_core_rst", int'(core_rst), 1);
      dchk("glitch_core_en", int'(core_en), 0);
      btn[0] = 1'b0;
      repeat (6) @(negedge clk);
      dchk("pre_press_en", int'(core_en), 0);
      @(negedge clk);
      dchk("reset_en", int'(core_en), 1);
      dchk("reset_rst", int'(core_rst), 1);
      repeat (3) @(negedge clk);
      dchk("reset_last_rst", int'(core_rst), 1);
      btn[0] = 1'b1;
      @(negedge clk);
      dchk("run_rst", int'(core_rst), 0);
      dchk("run_en", int'(core_en), 1);
      repeat (4) @(negedge clk);

      // walk pc to the end address
      for (int i = 0; i <= 16; i++) begin
         pc = N'(i * 4);
         @(negedge clk);
      end
      pc = '0;
      repeat (2) @(negedge clk);
      dchk("halt_flag", int'(halted), 1);
      dchk("halt_en", int'(core_en), 0);
      btn[0] = 1'b0;
      repeat (8) @(negedge clk);
      dchk("halt_exit_flag", int'(halted), 0);
      dchk("halt_exit_rst", int'(core_rst), 1);
      btn[0] = 1'b1;
      repeat (10) @(negedge clk);

      // debug mode, three single steps
      hit(1, 8, 8);
      dchk("wait_en", int'(core_en), 0);
      dchk("wait_dm", int'(dbg_mode), 1);
      en0 = en_cnt;
      repeat (3) hit(2, 8, 8);
      dchk("step_pulses", en_cnt - en0, 3);
      dchk("step_count3", int'(step_count), 3);
      hit(1, 8, 8);
      dchk("back_to_run", int'(core_en), 1);

      // dbg and stp together, then a bouncy stp
      hit(1, 8, 8);
      @(negedge clk);
      btn[1] = 1'b0;
      btn[2] = 1'b0;
      repeat (8) @(negedge clk);
      btn[1] = 1'b1;
      btn[2] = 1'b1;
      repeat (8) @(negedge clk);
      dchk("dual_run", int'(dbg_mode), 0);
      dchk("dual_count", int'(step_count), 3);
      hit(1, 8, 8);
      for (int i = 0; i < 6; i++) begin
         btn[2] = i[0];
         repeat (2) @(negedge clk);
      end
      hit(2, 8, 8);
      dchk("bounce_count", int'(step_count), 4);

      // held dbg through power press, then counter wrap
      btn[1] = 1'b0;
      repeat (10) @(negedge clk);
      hit(0, 10, 10);
      btn[1] = 1'b1;
      repeat (8) @(negedge clk);
      dchk("held_dbg_wait", int'(dbg_mode), 1);
      dchk("held_dbg_cnt", int'(step_count), 0);
      repeat (15) hit(2, 6, 6);
      dchk("count_max", int'(step_count), 15);
      hit(2, 6, 6);
      dchk("count_wrap", int'(step_count), 0);

      // asynchronous reset while in STEP
      @(negedge clk);
      btn[2] = 1'b0;
      found  = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         #1;
         if (mode == M_STEP) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL reach_step: got no STEP required STEP within 40 cycles");
      end else begin
         #1 rst = 1'b0;
         #1;
         dchk("async_en", int'(core_en), 0);
         dchk("async_rst", int'(core_rst), 1);
         dchk("async_dm", int'(dbg_mode), 0);
         dchk("async_sc", int'(step_count), 0);
      end
      btn[2] = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (4) @(negedge clk);
      dchk("post_rst_core_rst", int'(core_rst), 1);
      dchk("post_rst_en", int'(core_en), 0);

      // random buttons and pc
      repeat (3000) begin
         @(negedge clk);
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, (b == 0) ? 24 : 7) == 0) btn[b] = ~btn[b];
         end
         if ($urandom_range(0, 11) == 0) pc = HPC;
         else                            pc = N'($urandom) & 24'h3C;
      end
      btn = 3'b111;
      pc  = '0;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
